d_cell_cache: RTL

//  Single-cell write-back cache between the bfcpu execute stage and the data memory.

---
 rtl/d_cell_cache.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/d_cell_cache.sv
// Single-cell write-back cache for the bfcpu data pointer: keeps the current cell in a
// register and only talks to data memory on a pointer move or an explicit flush.
module d_cell_cache #(
    parameter int d_addr_width = 8,
    parameter int d_mem_length = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [2:0]              op_code,
    input  logic [7:0]              op_wdata,
    output logic [7:0]              cell_data,
    output logic                    cell_valid,
    output logic [d_addr_width-1:0] ptr,
    output logic                    d_req,
    output logic                    d_dir,
    output logic [d_addr_width-1:0] d_addr,
    output logic [7:0]              d_wdata,
    input  logic                    d_ack,
    input  logic [7:0]              d_rdata
);
    localparam int AW = d_addr_width;
    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;
    localparam logic [AW-1:0] LAST = AW'(d_mem_length - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_DEC   = 3'd1;
    localparam logic [2:0] OP_LEFT  = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;
    localparam logic [2:0] OP_SET   = 3'd4;
    localparam logic [2:0] OP_FLUSH = 3'd5;

    typedef enum logic [1:0] {IDLE, WB, GAP, FILL} state_t;

    typedef struct packed {
        logic          req;
        logic          dir;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
    } mreq_t;

    state_t        state, state_next;
    mreq_t         mreq;
    logic          dirty;
    logic          move_pend;
    logic [AW-1:0] move_tgt;
    logic          accept;
    logic          is_move;
    logic [AW-1:0] target;

    assign op_ready   = (state == IDLE);
    assign cell_valid = (state != FILL);
    assign d_req      = mreq.req;
    assign d_dir      = mreq.dir;
    assign d_addr     = mreq.addr;
    assign d_wdata    = mreq.wdata;

    assign accept  = op_valid && (state == IDLE);
    assign is_move = accept && (op_code == OP_LEFT || op_code == OP_RIGHT);

    always_comb begin
        target = (ptr == LAST) ? '0 : ptr + ONE;
        if (op_code == OP_LEFT)
            target = (ptr == '0) ? LAST : ptr - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (is_move)
                    state_next = dirty ? WB : FILL;
                else if (accept && op_code == OP_FLUSH && dirty)
                    state_next = WB;
            end
            WB:   if (mreq.req && d_ack) state_next = GAP;
            GAP:  state_next = move_pend ? FILL : IDLE;
            FILL: if (mreq.req && d_ack) state_next = IDLE;
            default: state_next = FILL;
        endcase
    end

    // Every transfer is launched on the edge that enters WB/FILL, so the request is
    // already up in the first cycle of the state and the ack lands in its second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreq      <= '{req: 1'b0, dir: DIR_READ, addr: '0, wdata: '0};
            ptr       <= '0;
            cell_data <= '0;
            dirty     <= 1'b0;
            move_pend <= 1'b0;
            move_tgt  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    case (op_code)
                        OP_INC: begin cell_data <= cell_data + 8'd1; dirty <= 1'b1; end
                        OP_DEC: begin cell_data <= cell_data - 8'd1; dirty <= 1'b1; end
                        OP_SET: begin cell_data <= op_wdata;         dirty <= 1'b1; end
                        OP_LEFT, OP_RIGHT: begin
                            if (dirty) begin
                                move_pend <= 1'b1;
                                move_tgt  <= target;
                                mreq      <= '{req: 1'b1, dir: DIR_WRITE, addr: ptr, wdata: cell_data};
                            end else begin
                                ptr       <= target;
                                mreq.req  <= 1'b1;
                                mreq.dir  <= DIR_READ;
                                mreq.addr <= target;
                            end
                        end
                        OP_FLUSH: if (dirty) begin
                            move_pend <= 1'b0;
                            mreq      <= '{req: 1'b1, dir: DIR_WRITE, addr: ptr, wdata: cell_data};
                        end
                        default: ;
                    endcase
                end
                WB: if (mreq.req && d_ack) begin
                    dirty    <= 1'b0;
                    mreq.req <= 1'b0;
                    mreq.dir <= DIR_READ;
                end
                GAP: if (move_pend) begin
                    ptr       <= move_tgt;
                    move_pend <= 1'b0;
                    mreq.req  <= 1'b1;
                    mreq.dir  <= DIR_READ;
                    mreq.addr <= move_tgt;
                end
                FILL: begin
                    // Coming out of reset the request is not yet up; launch it here.
                    if (!mreq.req) begin
                        mreq.req  <= 1'b1;
                        mreq.dir  <= DIR_READ;
                        mreq.addr <= ptr;
                    end else if (d_ack) begin
                        cell_data <= d_rdata;
                        mreq.req  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
